// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: master-state codes,
// tick-sequencer states, default speed constants and the speed formula.
package snake_pkg;

  localparam logic [1:0] MS_IDLE = 2'd0;
  localparam logic [1:0] MS_PLAY = 2'd1;
  localparam logic [1:0] MS_WIN  = 2'd2;
  localparam logic [1:0] MS_LOSE = 2'd3;

  localparam logic [7:0] BASE_FRAMES_DEF = 8'd6;
  localparam logic [7:0] MIN_FRAMES_DEF  = 8'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_MOVE  = 3'd2,
    ST_CHECK = 3'd3,
    ST_REQ   = 3'd4,
    ST_DONE  = 3'd5
  } tick_state_e;

  // Frames per tick: max(min_f, base - score), never wrapping below zero.
  function automatic logic [7:0] tick_period(input logic [7:0] base,
                                             input logic [7:0] min_f,
                                             input logic [3:0] score);
    logic [7:0] diff;
    if ({4'd0, score} < base) begin
      diff = base - {4'd0, score};
    end else begin
      diff = 8'd0;
    end
    if (diff < min_f) begin
      return min_f;
    end else begin
      return diff;
    end
  endfunction

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Signal bundle between the tick scheduler and the rest of the snake game.
// master = the scheduler itself, slave = the surrounding blocks.
interface game_tick_scheduler_if;
  logic       VS;
  logic [1:0] MASTER_STATE;
  logic [3:0] SCORE;
  logic       REACHED_TARGET;
  logic       NEXT_ACK;
  logic       GAMECLOCK;
  logic       SHIFT_BODY;
  logic       MOVE_HEAD;
  logic       NEXT_REQ;
  logic       BUSY;
  logic       OVERRUN;
  logic       ACK_ERR;

  modport master (
    input  VS, MASTER_STATE, SCORE, REACHED_TARGET, NEXT_ACK,
    output GAMECLOCK, SHIFT_BODY, MOVE_HEAD, NEXT_REQ, BUSY, OVERRUN, ACK_ERR
  );

  modport slave (
    output VS, MASTER_STATE, SCORE, REACHED_TARGET, NEXT_ACK,
    input  GAMECLOCK, SHIFT_BODY, MOVE_HEAD, NEXT_REQ, BUSY, OVERRUN, ACK_ERR
  );
endinterface

// File: rtl/vs_edge_sync.sv
// Two-flop synchroniser plus falling-edge detector for an active-low
// asynchronous strobe (VS, HS, ...). The one-cycle pulse appears three
// clock edges after the input falls.
module vs_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic fall
);
  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic fall_r;

  // Synchronise the input (idle-high) and register the falling-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
      fall_r  <= 1'b0;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      fall_r  <= prev_r & ~sync2_r;
    end
  end

  assign fall = fall_r;
endmodule

// File: rtl/game_tick_scheduler.sv
// Derives game ticks from frame sync (faster as score rises) and walks the
// snake datapath through shift / move / check / respawn-request per tick.
module game_tick_scheduler
  import snake_pkg::*;
#(
  parameter logic [7:0]  BASE_FRAMES  = BASE_FRAMES_DEF,
  parameter logic [7:0]  MIN_FRAMES   = MIN_FRAMES_DEF,
  parameter int unsigned CHECK_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT  = 64
) (
  input logic CLOCK,
  input logic RESET,
  game_tick_scheduler_if.master bus
);
  // Step counter is 8 bits wide: CHECK_CYCLES and ACK_TIMEOUT must be <= 256.
  localparam logic [7:0] CHECK_LAST = 8'(CHECK_CYCLES - 1);
  localparam logic [7:0] ACK_LAST   = 8'(ACK_TIMEOUT - 1);

  logic        frame_s;
  logic        play_s;
  logic [7:0]  period_s;
  logic        tick_due_s;
  logic        start_s;
  logic        ack_err_set_s;
  logic [7:0]  frame_cnt_r;
  logic [7:0]  step_cnt_r;
  logic [7:0]  step_cnt_s;
  tick_state_e state_r;
  tick_state_e state_s;
  logic        gameclock_r;
  logic        shift_body_r;
  logic        move_head_r;
  logic        next_req_r;
  logic        busy_r;
  logic        overrun_r;
  logic        ack_err_r;

  vs_edge_sync u_vs_sync (
    .clk      (CLOCK),
    .rst_n    (RESET),
    .async_in (bus.VS),
    .fall     (frame_s)
  );

  assign play_s     = (bus.MASTER_STATE == MS_PLAY);
  assign period_s   = tick_period(BASE_FRAMES, MIN_FRAMES, bus.SCORE);
  assign tick_due_s = frame_s & play_s & ((frame_cnt_r + 8'd1) >= period_s);
  // A due tick only starts when nothing is in flight; otherwise it is dropped.
  assign start_s    = tick_due_s & ~busy_r;

  // Count frames toward the next tick; parked at zero outside PLAY.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      frame_cnt_r <= 8'd0;
    end else if (!play_s) begin
      frame_cnt_r <= 8'd0;
    end else if (frame_s) begin
      frame_cnt_r <= tick_due_s ? 8'd0 : (frame_cnt_r + 8'd1);
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Next-state logic for the per-tick update sequence.
  always_comb begin
    state_s       = state_r;
    step_cnt_s    = step_cnt_r;
    ack_err_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (gameclock_r) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: state_s = ST_MOVE;
      ST_MOVE: begin
        state_s    = ST_CHECK;
        step_cnt_s = 8'd0;
      end
      ST_CHECK: begin
        if (step_cnt_r == CHECK_LAST) begin
          step_cnt_s = 8'd0;
          state_s    = bus.REACHED_TARGET ? ST_REQ : ST_DONE;
        end else begin
          step_cnt_s = step_cnt_r + 8'd1;
        end
      end
      ST_REQ: begin
        if (bus.NEXT_ACK) begin
          state_s = ST_DONE;
        end else if (step_cnt_r == ACK_LAST) begin
          state_s       = ST_DONE;
          ack_err_set_s = 1'b1;
        end else begin
          step_cnt_s = step_cnt_r + 8'd1;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus outputs registered from the upcoming state.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_r      <= ST_IDLE;
      step_cnt_r   <= 8'd0;
      gameclock_r  <= 1'b0;
      shift_body_r <= 1'b0;
      move_head_r  <= 1'b0;
      next_req_r   <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
      ack_err_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      step_cnt_r   <= step_cnt_s;
      gameclock_r  <= start_s;
      shift_body_r <= (state_s == ST_SHIFT);
      move_head_r  <= (state_s == ST_MOVE);
      next_req_r   <= (state_s == ST_REQ);
      busy_r       <= (state_s != ST_IDLE) | start_s;
      overrun_r    <= overrun_r | (tick_due_s & busy_r);
      ack_err_r    <= ack_err_r | ack_err_set_s;
    end
  end

  assign bus.GAMECLOCK  = gameclock_r;
  assign bus.SHIFT_BODY = shift_body_r;
  assign bus.MOVE_HEAD  = move_head_r;
  assign bus.NEXT_REQ   = next_req_r;
  assign bus.BUSY       = busy_r;
  assign bus.OVERRUN    = overrun_r;
  assign bus.ACK_ERR    = ack_err_r;
endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: stimulus drives VS frames and pushes the
// expected tick (start cycle, busy length, request length) to a queue; a
// monitor pops and checks each sequence the DUT produces.
module tb_game_tick_scheduler;
  import snake_pkg::*;

  typedef struct {
    int gc;
    int blen;
    int rlen;
    bit chk;
  } exp_t;

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;
  game_tick_scheduler_if bus();

  game_tick_scheduler #(
    .BASE_FRAMES  (8'd6),
    .MIN_FRAMES   (8'd2),
    .CHECK_CYCLES (2),
    .ACK_TIMEOUT  (64)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   gc_pushed = 0;
  int   gc_seen = 0;
  int   mcnt = 0;
  int   busy_end = -1;
  bit   exp_overrun = 1'b0;
  int   ack_delay = -1;
  bit   target = 1'b0;
  bit   nochk = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_ms(input logic [1:0] m);
    bus.MASTER_STATE = m;
    if (m != MS_PLAY) mcnt = 0;
  endtask

  // Drop VS now and predict what the frame it creates will do.
  task automatic vs_fall();
    int c, f, p, rl;
    exp_t e;
    c = cyc;
    f = c + 3;
    bus.VS = 1'b0;
    if (bus.MASTER_STATE == MS_PLAY) begin
      p = 6 - int'(bus.SCORE);
      if (p < 2) p = 2;
      if (mcnt + 1 >= p) begin
        mcnt = 0;
        if (f <= busy_end) begin
          exp_overrun = 1'b1;
        end else begin
          rl = !target ? 0 : (ack_delay == 0 ? 1 : (ack_delay < 0 ? 64 : ack_delay));
          e.gc = c + 4;
          e.blen = 6 + rl;
          e.rlen = rl;
          e.chk = !nochk;
          q.push_back(e);
          gc_pushed++;
          busy_end = c + 4 + 6 + rl - 1;
        end
      end else begin
        mcnt++;
      end
    end else begin
      mcnt = 0;
    end
  endtask

  task automatic frames(input int n, input int gap);
    repeat (n) begin
      vs_fall();
      repeat (4) step();
      bus.VS = 1'b1;
      repeat (gap - 4) step();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gameclock"}, int'(bus.GAMECLOCK), 0);
    check({tag, "_shift_body"}, int'(bus.SHIFT_BODY), 0);
    check({tag, "_move_head"}, int'(bus.MOVE_HEAD), 0);
    check({tag, "_next_req"}, int'(bus.NEXT_REQ), 0);
    check({tag, "_busy"}, int'(bus.BUSY), 0);
    check({tag, "_overrun"}, int'(bus.OVERRUN), 0);
    check({tag, "_ack_err"}, int'(bus.ACK_ERR), 0);
  endtask

  // Random-generator model: acks after ack_delay cycles of NEXT_REQ
  // (0 = ack held high beforehand, negative = never).
  initial begin
    int req_seen;
    req_seen = 0;
    bus.NEXT_ACK = 1'b0;
    forever begin
      @(negedge CLOCK);
      if (ack_delay == 0) begin
        bus.NEXT_ACK = 1'b1;
      end else if (bus.NEXT_REQ) begin
        req_seen++;
        if (ack_delay > 0 && req_seen >= ack_delay) bus.NEXT_ACK = 1'b1;
      end else begin
        req_seen = 0;
        bus.NEXT_ACK = 1'b0;
      end
    end
  end

  // Monitor: every GAMECLOCK pops one expected sequence and checks it.
  initial begin
    exp_t e;
    int nb, nr;
    forever begin
      @(negedge CLOCK);
      if (RESET && bus.GAMECLOCK) begin
        gc_seen++;
        check("gameclock_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("gameclock_cycle", cyc, e.gc);
          check("busy_at_gameclock", int'(bus.BUSY), 1);
          @(negedge CLOCK);
          check("shift_cycle", int'({bus.GAMECLOCK, bus.SHIFT_BODY, bus.MOVE_HEAD}), 3'b010);
          @(negedge CLOCK);
          check("move_cycle", int'({bus.GAMECLOCK, bus.SHIFT_BODY, bus.MOVE_HEAD}), 3'b001);
          nb = 3;
          nr = 0;
          forever begin
            @(negedge CLOCK);
            if (!RESET || !bus.BUSY || nb >= 200) break;
            nb++;
            if (bus.NEXT_REQ) nr++;
            check("no_strobe_in_busy", int'({bus.GAMECLOCK, bus.SHIFT_BODY, bus.MOVE_HEAD}), 0);
          end
          if (e.chk) begin
            check("busy_len", nb, e.blen);
            check("next_req_len", nr, e.rlen);
          end
        end
      end
    end
  end

  initial begin
    int g;
    bus.VS = 1'b1;
    bus.MASTER_STATE = MS_IDLE;
    bus.SCORE = 4'd0;
    bus.REACHED_TARGET = 1'b0;
    RESET = 1'b0;
    repeat (3) step();
    check_zero("reset");
    RESET = 1'b1;
    repeat (3) step();

    // Base rate: one tick per 6 frames, plain sequence.
    set_ms(MS_PLAY);
    frames(12, 100);
    // Faster with score, clamped at 2 frames.
    bus.SCORE = 4'd3;
    frames(6, 100);
    bus.SCORE = 4'd9;
    frames(4, 100);
    // Period drops below the running count: tick on the next frame.
    bus.SCORE = 4'd0;
    frames(4, 100);
    bus.SCORE = 4'd5;
    frames(1, 100);

    // Target reached: ack after 5 cycles, then ack already high.
    bus.SCORE = 4'd0;
    target = 1'b1;
    bus.REACHED_TARGET = 1'b1;
    ack_delay = 5;
    frames(6, 100);
    check("ack_err_after_ack", int'(bus.ACK_ERR), 0);
    ack_delay = 0;
    frames(6, 100);

    // No ack: timeout after 64 cycles, sticky error.
    ack_delay = -1;
    frames(6, 100);
    check("ack_err_after_timeout", int'(bus.ACK_ERR), 1);
    check("idle_after_timeout", int'({bus.BUSY, bus.NEXT_REQ}), 0);
    check("overrun_before_fast", int'(bus.OVERRUN), int'(exp_overrun));

    // Frames every 10 cycles with a long request wait: overrun.
    bus.SCORE = 4'd4;
    ack_delay = 30;
    frames(10, 10);
    repeat (60) step();
    check("overrun_sticky", int'(bus.OVERRUN), int'(exp_overrun));
    check("ack_err_still_set", int'(bus.ACK_ERR), 1);

    // Leave PLAY during MOVE: sequence completes, no further ticks.
    target = 1'b0;
    bus.REACHED_TARGET = 1'b0;
    frames(1, 100);
    g = cyc + 4;
    vs_fall();
    while (cyc < g + 2) step();
    set_ms(MS_LOSE);
    bus.VS = 1'b1;
    repeat (94) step();
    frames(4, 100);
    check("idle_after_lose", int'(bus.BUSY), 0);

    // Asynchronous reset in the middle of a request wait.
    set_ms(MS_PLAY);
    target = 1'b1;
    bus.REACHED_TARGET = 1'b1;
    ack_delay = -1;
    frames(1, 100);
    nochk = 1'b1;
    vs_fall();
    repeat (4) step();
    bus.VS = 1'b1;
    for (int i = 0; i < 50 && !bus.NEXT_REQ; i++) step();
    check("req_before_reset", int'(bus.NEXT_REQ), 1);
    repeat (10) step();
    #2;
    RESET = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (5) step();
    RESET = 1'b1;
    repeat (5) step();

    check("queue_drained", q.size(), 0);
    check("gameclock_count", gc_seen, gc_pushed);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
